// File: rtl/avalon_slave_modport.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_slave_modport
//  Description : Avalon-MM slave endpoint in front of a word-organised RAM.
//                Handles single/burst reads and writes with byte enables.
//                Read data returns with a fixed pipelined latency of TW
//                cycles after the command is accepted.
//                Optional macro AVS_RANGE_CHECK_EN: word indices >= DEPTH are
//                out of range (writes dropped, reads return all-ones).
//                When it is not defined, the word index wraps modulo DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_slave_modport #(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int TW    = 2,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   address_i,
    input  logic [DW/8-1:0] byteenable_i,
    input  logic            chipselect_i,
    input  logic            read_i,
    input  logic            write_i,
    input  logic [DW-1:0]   writedata_i,
    input  logic [3:0]      burstcount_i,
    input  logic            beginbursttransfer_i,
    output logic [DW-1:0]   readdata_o,
    output logic            waitrequest_o,
    output logic            readdatavalid_o
);

    localparam int NB   = DW / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IW   = $clog2(DEPTH);
    localparam int WAW  = AW - OFFW;
    // Extra RWAIT cycles after acceptance before the first beat is registered
    localparam logic [2:0] LAT_INIT = 3'((TW > 1) ? (TW - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WBURST = 2'd1,
        S_RWAIT  = 2'd2,
        S_RDATA  = 2'd3
    } state_t;

    state_t          state_q;
    logic [WAW-1:0]  base_q;
    logic [3:0]      cnt_q;
    logic [3:0]      beat_q;
    logic [2:0]      lat_q;
    logic            waitreq_q;
    logic            rvalid_q;
    logic [DW-1:0]   rdata_q;

    logic [DW-1:0]   mem_q [DEPTH];

    logic            accept;
    logic [WAW-1:0]  addr_word;
    logic [WAW-1:0]  seq_word;
    logic [3:0]      bcount;
    logic            in_read;
    logic [WAW-1:0]  rd_word;
    logic [WAW-1:0]  wr_word;
    logic            rd_oor;
    logic            wr_oor;
    logic            wr_en;
    logic [DW-1:0]   rd_data;
    logic            unused_misc;

    assign accept    = chipselect_i & (read_i | write_i) & ~waitreq_q;
    assign addr_word = address_i[AW-1:OFFW];
    // Burst beat i addresses base+i; the add simply rolls over the index field
    assign seq_word  = base_q + WAW'(beat_q);
    assign bcount    = (burstcount_i == 4'd0) ? 4'd1 : burstcount_i;
    assign in_read   = (state_q == S_RWAIT) || (state_q == S_RDATA);
    // A beat issued at the accepting edge (TW=1) uses the incoming address
    assign rd_word   = in_read ? seq_word : addr_word;
    assign wr_word   = (state_q == S_WBURST) ? seq_word : addr_word;

`ifdef AVS_RANGE_CHECK_EN
    assign rd_oor = |rd_word[WAW-1:IW];
    assign wr_oor = |wr_word[WAW-1:IW];
`else
    logic unused_upper;
    assign rd_oor       = 1'b0;
    assign wr_oor       = 1'b0;
    assign unused_upper = ^{rd_word[WAW-1:IW], wr_word[WAW-1:IW]};
`endif

    assign wr_en       = accept & write_i & ~wr_oor;
    assign rd_data     = rd_oor ? {DW{1'b1}} : mem_q[rd_word[IW-1:0]];
    assign unused_misc = ^{address_i[OFFW-1:0], beginbursttransfer_i};

    assign readdata_o      = rdata_q;
    assign waitrequest_o   = waitreq_q;
    assign readdatavalid_o = rvalid_q;

    // RAM write port: each enabled byte lane of the addressed word updates
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (byteenable_i[i]) begin
                    mem_q[wr_word[IW-1:0]][8*i +: 8] <= writedata_i[8*i +: 8];
                end
            end
        end
    end

    // Command FSM with registered waitrequest, readdata and readdatavalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            cnt_q     <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            waitreq_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_WBURST: begin
                    waitreq_q <= 1'b0;
                    if (accept && write_i) begin
                        if (state_q == S_IDLE) begin
                            if (bcount > 4'd1) begin
                                base_q  <= addr_word;
                                cnt_q   <= bcount;
                                beat_q  <= 4'd1;
                                state_q <= S_WBURST;
                            end
                        end else if (beat_q == cnt_q - 4'd1) begin
                            state_q <= S_IDLE;
                        end else begin
                            beat_q <= beat_q + 4'd1;
                        end
                    end else if (accept) begin
                        // Read: also abandons any write burst in progress
                        base_q <= addr_word;
                        cnt_q  <= bcount;
                        if (TW == 1) begin
                            rvalid_q <= 1'b1;
                            rdata_q  <= rd_data;
                            if (bcount == 4'd1) begin
                                state_q <= S_IDLE;
                            end else begin
                                beat_q    <= 4'd1;
                                waitreq_q <= 1'b1;
                                state_q   <= S_RDATA;
                            end
                        end else begin
                            beat_q    <= 4'd0;
                            lat_q     <= LAT_INIT;
                            waitreq_q <= 1'b1;
                            state_q   <= S_RWAIT;
                        end
                    end
                end
                S_RWAIT: begin
                    if (lat_q == 3'd0) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_data;
                        if (cnt_q == 4'd1) begin
                            waitreq_q <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            beat_q  <= 4'd1;
                            state_q <= S_RDATA;
                        end
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                S_RDATA: begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= rd_data;
                    if (beat_q == cnt_q - 4'd1) begin
                        waitreq_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        beat_q <= beat_q + 4'd1;
                    end
                end
                default: begin
                    waitreq_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_avalon_slave_modport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_slave_modport
//  Description : Self-checking bench for avalon_slave_modport. Directed
//                vector table, hand-written burst/reset sequences and a
//                randomized phase checked against an array-based memory model.
//                Honours AVS_RANGE_CHECK_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_slave_modport;

    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int TW    = 2;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   address = '0;
    logic [7:0]    byteenable = '0;
    logic          chipselect = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [63:0]   writedata = '0;
    logic [3:0]    burstcount = '0;
    logic          beginbursttransfer = 1'b0;
    logic [63:0]   readdata;
    logic          waitrequest;
    logic          readdatavalid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mem_m [DEPTH];
    logic [63:0] wdata_buf [16];
    logic [7:0]  be_buf [16];
    logic [63:0] rbeats [16];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [9];

    avalon_slave_modport #(.AW(AW), .DW(DW), .TW(TW), .DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .address_i            (address),
        .byteenable_i         (byteenable),
        .chipselect_i         (chipselect),
        .read_i               (read),
        .write_i              (write),
        .writedata_i          (writedata),
        .burstcount_i         (burstcount),
        .beginbursttransfer_i (beginbursttransfer),
        .readdata_o           (readdata),
        .waitrequest_o        (waitrequest),
        .readdatavalid_o      (readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: word for beat i of a burst starting at byte address addr
    function automatic bit model_in_range(input logic [31:0] addr, input int i);
        longint unsigned w;
        w = 64'(addr >> 3) + 64'(i);
`ifdef AVS_RANGE_CHECK_EN
        return (w < DEPTH);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] addr, input int i);
        longint unsigned w;
        w = 64'(addr >> 3) + 64'(i);
        return int'(w % DEPTH);
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] addr, input int i);
        if (!model_in_range(addr, i)) return '1;
        return mem_m[model_idx(addr, i)];
    endfunction

    task automatic model_write(input logic [31:0] addr, input int i,
                               input logic [63:0] data, input logic [7:0] be);
        if (model_in_range(addr, i)) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem_m[model_idx(addr, i)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endtask

    task automatic bus_idle();
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        beginbursttransfer = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (waitrequest !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", waitrequest, 1'b0);
    endtask

    // Issue nbeats beats of a write burst; later beats carry junk address/count
    task automatic wr_burst(input logic [31:0] addr, input logic [3:0] bc,
                            input int nbeats, input int gap_at);
        for (int i = 0; i < nbeats; i++) begin
            if (i == gap_at) @(negedge clk);
            wait_ready();
            chipselect = 1'b1;
            write      = 1'b1;
            read       = 1'b0;
            address    = (i == 0) ? addr : $urandom;
            burstcount = (i == 0) ? bc : 4'($urandom);
            beginbursttransfer = (i == 0);
            writedata  = wdata_buf[i];
            byteenable = be_buf[i];
            @(negedge clk);
            model_write(addr, i, wdata_buf[i], be_buf[i]);
            bus_idle();
        end
    endtask

    // Read burst; checks readdatavalid/waitrequest each cycle and data per beat
    task automatic rd_burst(input logic [31:0] addr, input logic [3:0] bc);
        int n = (bc == 4'd0) ? 1 : int'(bc);
        bit exp_v;
        wait_ready();
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = addr;
        burstcount = bc;
        byteenable = 8'($urandom);
        @(negedge clk);
        bus_idle();
        for (int k = 0; k <= TW + n - 1; k++) begin
            exp_v = (k >= TW - 1) && (k <= TW + n - 2);
            check("rd_valid", 64'(readdatavalid), 64'(exp_v));
            check("rd_waitreq", 64'(waitrequest), 64'(k < TW + n - 2));
            if (exp_v) begin
                rbeats[k - (TW - 1)] = readdata;
                check("rd_data", readdata, model_read(addr, k - (TW - 1)));
            end
            if (k < TW + n - 1) @(negedge clk);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h10, 64'h0011223344556677, 8'hFF, 64'h0};
        tbl[1] = '{1'b0, 32'h10, 64'h0, 8'h00, 64'h0011223344556677};
        tbl[2] = '{1'b1, 32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 64'h0};
        tbl[3] = '{1'b0, 32'h10, 64'h0, 8'h00, 64'h00112233FFFFFFFF};
        tbl[4] = '{1'b1, 32'h18, 64'h0, 8'hFF, 64'h0};
        tbl[5] = '{1'b1, 32'h18, 64'hDEADBEEFCAFEF00D, 8'h81, 64'h0};
        tbl[6] = '{1'b0, 32'h1C, 64'h0, 8'h00, 64'hDE0000000000000D};
        tbl[7] = '{1'b1, 32'h27, 64'h123456789ABCDEF0, 8'hFF, 64'h0};
        tbl[8] = '{1'b0, 32'h20, 64'h0, 8'h00, 64'h123456789ABCDEF0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_waitreq", 64'(waitrequest), 64'd1);
        check("rst_valid", 64'(readdatavalid), 64'd0);
        check("rst_rdata", readdata, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_waitreq_hold", 64'(waitrequest), 64'd1);
        @(negedge clk);
        check("rel_waitreq_fall", 64'(waitrequest), 64'd0);
        check("rel_valid", 64'(readdatavalid), 64'd0);

        // Preload the whole RAM through 8-beat bursts
        for (int b = 0; b < DEPTH / 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                wdata_buf[i] = {$urandom, $urandom};
                be_buf[i]    = 8'hFF;
            end
            wr_burst(32'(b * 64), 4'd8, 8, (b % 3 == 0) ? 3 : -1);
        end

        // Directed vector table
        for (int t = 0; t < 9; t++) begin
            if (tbl[t].is_wr) begin
                wdata_buf[0] = tbl[t].data;
                be_buf[0]    = tbl[t].be;
                wr_burst(tbl[t].addr, 4'd1, 1, -1);
            end else begin
                rd_burst(tbl[t].addr, 4'd1);
                check($sformatf("tbl_%0d", t), rbeats[0], tbl[t].exp);
            end
        end

        // Write burst of 4 with an idle cycle between beats 2 and 3, read back
        for (int i = 0; i < 4; i++) begin
            wdata_buf[i] = 64'(i + 1);
            be_buf[i]    = 8'hFF;
        end
        wr_burst(32'h40, 4'd4, 4, 2);
        rd_burst(32'h40, 4'd4);
        for (int i = 0; i < 4; i++) check("burst4_beat", rbeats[i], 64'(i + 1));

        // Read and write together: write wins, no read data
        wait_ready();
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        address = 32'h08; burstcount = 4'd1; writedata = 64'hA5; byteenable = 8'hFF;
        @(negedge clk);
        bus_idle();
        model_write(32'h08, 0, 64'hA5, 8'hFF);
        for (int k = 0; k < TW + 2; k++) begin
            check("rw_no_valid", 64'(readdatavalid), 64'd0);
            @(negedge clk);
        end
        rd_burst(32'h08, 4'd0);
        check("rw_write_won", rbeats[0], 64'hA5);

        // Write burst abandoned by a read, then a fresh single write
        wdata_buf[0] = 64'h1111; wdata_buf[1] = 64'h2222;
        be_buf[0] = 8'hFF; be_buf[1] = 8'hFF;
        wr_burst(32'h80, 4'd4, 2, -1);
        rd_burst(32'h80, 4'd2);
        wdata_buf[0] = 64'h3333;
        wr_burst(32'h100, 4'd1, 1, -1);
        rd_burst(32'h100, 4'd1);
        check("abort_new_write", rbeats[0], 64'h3333);
        rd_burst(32'h90, 4'd1);
        check("abort_untouched", rbeats[0], model_read(32'h90, 0));

        // Addresses past DEPTH and bursts crossing the top word
`ifdef AVS_RANGE_CHECK_EN
        rd_burst(32'h800, 4'd1);
        check("oor_read_ones", rbeats[0], 64'hFFFFFFFFFFFFFFFF);
        wdata_buf[0] = 64'hBADBADBADBAD; be_buf[0] = 8'hFF;
        wr_burst(32'h800, 4'd1, 1, -1);
        rd_burst(32'h0, 4'd1);
        check("oor_word0_kept", rbeats[0], mem_m[0]);
        rd_burst(32'h7F0, 4'd4);
        check("oor_beat3_ones", rbeats[3], 64'hFFFFFFFFFFFFFFFF);
`else
        rd_burst(32'h800, 4'd1);
        check("wrap_read_word0", rbeats[0], mem_m[0]);
        wdata_buf[0] = 64'h0BADF00D; be_buf[0] = 8'hFF;
        wr_burst(32'h800, 4'd1, 1, -1);
        rd_burst(32'h0, 4'd1);
        check("wrap_write_word0", rbeats[0], 64'h0BADF00D);
        rd_burst(32'h7F0, 4'd4);
        check("wrap_beat3", rbeats[3], mem_m[1]);
`endif

        // Randomized mix of bursts against the model
        for (int r = 0; r < 60; r++) begin
            logic [31:0] a;
            logic [3:0]  bc;
            int          n;
            a  = 32'($urandom_range(0, 4 * DEPTH * 8 - 1));
            bc = 4'($urandom_range(0, 15));
            n  = (bc == 4'd0) ? 1 : int'(bc);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin
                    wdata_buf[i] = {$urandom, $urandom};
                    be_buf[i]    = 8'($urandom);
                end
                wr_burst(a, bc, n, $urandom_range(0, n));
            end else begin
                rd_burst(a, bc);
            end
        end

        // Reset asserted while the second beat of a 4-beat read is on the bus
        for (int i = 0; i < 4; i++) begin
            wdata_buf[i] = 64'(16 + i);
            be_buf[i]    = 8'hFF;
        end
        wr_burst(32'h40, 4'd4, 4, -1);
        wait_ready();
        chipselect = 1'b1; read = 1'b1; write = 1'b0;
        address = 32'h40; burstcount = 4'd4;
        @(negedge clk);
        bus_idle();
        repeat (TW) @(negedge clk);
        check("mid_beat2_valid", 64'(readdatavalid), 64'd1);
        check("mid_beat2_data", readdata, 64'd17);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(readdatavalid), 64'd0);
        check("mid_rst_waitreq", 64'(waitrequest), 64'd1);
        check("mid_rst_rdata", readdata, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_waitreq", 64'(waitrequest), 64'd0);
        for (int k = 0; k < 5; k++) begin
            check("mid_no_more_beats", 64'(readdatavalid), 64'd0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/avalon_slave_modport.md
# avalon_slave_modport

Avalon-MM slave endpoint: a word-organised on-chip RAM behind the slave side of the team's Avalon bus interface. It accepts single and burst reads and writes from one Avalon master, honours byte enables, and returns read data with a fixed pipelined latency. It is the reference target the master agent drives in block and bridge testbenches.

## Interface
- AW, 32, address width (byte address)
- DW, 64, data width; DW/8 byte lanes
- TW, 2, read latency in cycles from command acceptance to first readdatavalid (legal 1..8)
- DEPTH, 256, number of DW-bit words (power of two)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- address  in  AW  byte address; word index = address >> log2(DW/8)
- byteenable  in  DW/8  write lane enables, bit i covers writedata[8i+7:8i]
- chipselect  in  1  qualifies read/write
- read  in  1  read request
- write  in  1  write request / write beat
- writedata  in  DW  write data
- burstcount  in  4  beats in burst; 0 treated as 1
- beginbursttransfer  in  1  marks first cycle of a burst (informational; command acceptance alone starts a burst)
- readdata  out  DW  read data, valid when readdatavalid
- waitrequest  out  1  slave busy; command not accepted while high
- readdatavalid  out  1  one pulse per returned read beat

## Operation
- Command accepted at a rising edge when chipselect & (read | write) & !waitrequest.
- read and write both high: write wins, read ignored.
- Write burst: first accepted write loads base word and count = burstcount; each accepted write beat stores word base+i, lanes gated by byteenable; master may idle (write low) between beats; after count beats slave returns to idle. Read accepted mid write burst aborts remaining beats.
- Read burst: one accepted read loads base and count; slave returns count beats, word base+i on beat i, on consecutive cycles; waitrequest high from the cycle after acceptance until the edge of the last beat.
- States: IDLE, WBURST, RWAIT (latency countdown), RDATA. IDLE->WBURST on write with count>1; IDLE->RWAIT on read; RWAIT->RDATA after TW-1 cycles; RDATA->IDLE after last beat; WBURST->IDLE after last beat.
- Word index arithmetic modulo DEPTH (see Configuration); burst incrementing crosses the wrap without stalling.
- byteenable ignored on reads; full word returned.

## Timing
- Reset values: readdata 0, readdatavalid 0, waitrequest 1; state IDLE, counters 0. Memory contents not reset.
- waitrequest falls on first rising edge after rst_n deasserts.
- Read accepted at edge N: readdatavalid high for cycles following edges N+TW-1 .. N+TW+count-2, i.e. first beat sampled by master at edge N+TW.
- Writes take effect at the accepting edge; read of same word accepted next cycle returns new data.
- waitrequest, readdata, readdatavalid are registered outputs.
- Reset asserted mid-burst: outputs go to reset values immediately, burst abandoned, no further beats.

## Configuration
- AVS_RANGE_CHECK_EN defined: word index ≥ DEPTH (address bits above the index field non-zero) is out of range; writes dropped, read beats return all-ones with readdatavalid still pulsed; burst beats checked individually.
- Not defined: upper address bits ignored, index wraps modulo DEPTH.

## Test plan
- Reset then idle: waitrequest 1 during reset, 0 one edge after release; readdatavalid 0, readdata 0.
- Single write 0x0011223344556677 to address 0x10, byteenable 0xFF; read 0x10 with TW=2 -> readdatavalid one cycle, readdata 0x0011223344556677 sampled 2 edges after acceptance.
- Byteenable 0x0F write of 0xFFFFFFFFFFFFFFFF over that word -> read returns 0x00112233FFFFFFFF.
- Write burst burstcount=4 at 0x40 data 1,2,3,4 with an idle cycle between beats 2 and 3; read burst 4 at 0x40 -> four consecutive valid beats 1,2,3,4, waitrequest high until last beat, then low.
- Simultaneous read & write to 0x08 data 0xA5 -> write performed, no readdatavalid; burstcount=0 read -> exactly one beat.
- Address 0x800 (word 256): without macro read returns word 0 content; with AVS_RANGE_CHECK_EN returns all-ones and word 0 unchanged after write to 0x800; reset asserted during read burst beat 2 -> readdatavalid drops immediately, no further beats.
